// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_pc4   <= i_pc4;
        r_valid <= 1'b1;
      end else begin
        // Bubble keeps the last PC fields; only InstrD/ValidD are meaningful.
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request FSM, PCF and the stalled-response buffer.
//   state    | meaning
//   ST_ISSUE | drive ImemReq for PCF unless StallF/PCSrcE
//   ST_WAIT  | one request outstanding, waiting for ImemValid
//   ST_HOLD  | response captured while StallD=1, waiting to load IF/ID
//   ST_DROP  | redirected while waiting; next response is stale
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pcf;
  logic [31:0]  w_pcf_nxt;
  logic [31:0]  w_pcf_plus4;
  logic [31:0]  r_hold_instr;
  logic [31:0]  w_load_instr;
  logic         w_req;
  logic         w_consume;
  logic         w_hold_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ISSUE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_consume   = 1'b0;
    w_hold_load = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (!StallF && !PCSrcE) begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PCSrcE) begin
          w_state_nxt = ImemValid ? ST_ISSUE : ST_DROP;
        end else if (ImemValid) begin
          if (StallD) begin
            w_hold_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_consume   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          w_state_nxt = ST_ISSUE;
        end else if (!StallD) begin
          w_consume   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DROP: begin
        if (ImemValid) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_ISSUE;
    endcase
  end

  assign w_pcf_plus4 = r_pcf + 32'd4;

  // A consumed word always advances PCF, even under StallF, so it is never refetched.
  always_comb begin
    w_pcf_nxt = r_pcf;
    if (PCSrcE) begin
      w_pcf_nxt = PCTargetE;
    end else if (w_consume) begin
      w_pcf_nxt = w_pcf_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf <= RESET_PC;
    end else begin
      r_pcf <= w_pcf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= 32'h0;
    end else if (w_hold_load) begin
      r_hold_instr <= ImemRData;
    end else if (r_state == ST_HOLD && w_state_nxt != ST_HOLD) begin
      r_hold_instr <= 32'h0;
    end
  end

  assign w_load_instr = (r_state == ST_HOLD) ? r_hold_instr : ImemRData;

  assign ImemReq  = w_req & rst_n;
  assign ImemAddr = r_pcf;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (FlushD | PCSrcE),
    .i_stall (StallD),
    .i_load  (w_consume),
    .i_instr (w_load_instr),
    .i_pc    (r_pcf),
    .i_pc4   (w_pcf_plus4),
    .o_instr (InstrD),
    .o_pc    (PCD),
    .o_pc4   (PCPlus4D),
    .o_valid (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, scoreboard of IF/ID loads, and cycle checks.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq, ImemValid, ValidD;
  logic [31:0] ImemAddr, ImemRData, InstrD, PCD, PCPlus4D;

  logic        wr_ImemReq, wr_ImemValid, wr_ValidD;
  logic [31:0] wr_ImemAddr, wr_ImemRData, wr_InstrD, wr_PCD, wr_PCPlus4D;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemValid(ImemValid), .ImemRData(ImemRData), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(zero1), .StallD(zero1), .FlushD(zero1),
    .PCSrcE(zero1), .PCTargetE(zero32), .ImemReq(wr_ImemReq), .ImemAddr(wr_ImemAddr),
    .ImemValid(wr_ImemValid), .ImemRData(wr_ImemRData), .InstrD(wr_InstrD), .PCD(wr_PCD),
    .PCPlus4D(wr_PCPlus4D), .ValidD(wr_ValidD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00A0_0113;
      32'h0000_0008: mem_word = 32'h00F0_0193;
      32'h0000_000C: mem_word = 32'h0140_0213;
      32'h0000_0100: mem_word = 32'h0640_0313;
      32'h0000_0104: mem_word = 32'h0C80_0393;
      32'h0000_0200: mem_word = 32'h7D00_0513;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Instruction memory model: fixed latency, one pending request, optional spurious strobe.
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic        req_s = 1'b0;
  logic [31:0] addr_s = 32'h0;
  logic        inject = 1'b0;

  always @(negedge clk) begin
    req_s  = ImemReq;
    addr_s = ImemAddr;
  end

  initial begin
    ImemValid = 1'b0;
    ImemRData = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      ImemValid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (req_s) begin
          chk("single_outstanding", 32'(pend), 32'h0);
          pend  = 1'b1;
          cnt   = lat;
          paddr = addr_s;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            ImemValid = 1'b1;
            ImemRData = mem_word(paddr);
            pend      = 1'b0;
          end
        end
      end
      if (inject) begin
        ImemValid = 1'b1;
        ImemRData = 32'hBAD0_0BAD;
        inject    = 1'b0;
      end
    end
  end

  // Monitor: every fresh valid IF/ID load must match the head of the scoreboard.
  logic        prev_v = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst_n && ValidD && (!prev_v || PCD != prev_pc)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_load: got instr %h pc %h, expected no load", InstrD, PCD);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", InstrD, e.instr);
        chk("sb_pcd", PCD, e.pc);
        chk("sb_pcplus4", PCPlus4D, e.pc4);
      end
    end
    prev_v  = ValidD;
    prev_pc = PCD;
  end

  task automatic cyc(input logic stf, input logic sd, input logic fd, input logic ps,
                     input logic [31:0] tgt);
    @(posedge clk);
    #1;
    StallF = stf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    #3;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t x;
    x.instr = instr; x.pc = pc; x.pc4 = pc4;
    sb.push_back(x);
  endtask

  initial begin
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    wr_ImemValid = 0; wr_ImemRData = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_req", 32'(ImemReq), 0);
    chk("rst_addr", ImemAddr, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_pc4", PCPlus4D, 0);
    chk("rst_valid", 32'(ValidD), 0);
    chk("rst_wrap_addr", wr_ImemAddr, 32'hFFFF_FFFC);
    chk("rst_wrap_req", 32'(wr_ImemReq), 0);

    // Basic streaming with a 1-cycle memory
    push(32'h0050_0093, 32'h0, 32'h4);
    push(32'h00A0_0113, 32'h4, 32'h8);
    @(posedge clk); #1; rst_n = 1'b1; #3;                 // C0
    chk("c0_req", 32'(ImemReq), 1);
    chk("c0_addr", ImemAddr, 32'h0);
    chk("c0_wrap_req", 32'(wr_ImemReq), 1);
    chk("c0_wrap_addr", wr_ImemAddr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);                                   // C1
    wr_ImemValid = 1'b1; wr_ImemRData = 32'h0010_0073;
    cyc(0, 0, 0, 0, 0);                                   // C2
    wr_ImemValid = 1'b0;
    chk("c2_valid", 32'(ValidD), 1);
    chk("c2_req", 32'(ImemReq), 1);
    chk("c2_addr", ImemAddr, 32'h4);
    chk("wrap_pcd", wr_PCD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", wr_PCPlus4D, 32'h0);
    chk("wrap_instr", wr_InstrD, 32'h0010_0073);
    chk("wrap_next_addr", wr_ImemAddr, 32'h0);
    cyc(0, 0, 0, 0, 0);                                   // C3
    chk("c3_bubble", 32'(ValidD), 0);
    cyc(1, 0, 0, 0, 0);                                   // C4
    chk("c4_valid", 32'(ValidD), 1);
    chk("stallf_blocks_req", 32'(ImemReq), 0);
    cyc(1, 0, 0, 0, 0);                                   // C5

    // Response lands while StallD=1 for three cycles
    push(32'h00F0_0193, 32'h8, 32'hC);
    cyc(0, 0, 0, 0, 0);                                   // C6
    chk("c6_req", 32'(ImemReq), 1);
    chk("c6_addr", ImemAddr, 32'h8);
    cyc(0, 1, 0, 0, 0);                                   // C7
    chk("c7_req", 32'(ImemReq), 0);
    for (int i = 0; i < 2; i++) begin                     // C8, C9
      cyc(0, 1, 0, 0, 0);
      chk("hold_req", 32'(ImemReq), 0);
      chk("hold_valid", 32'(ValidD), 0);
      chk("hold_instr", InstrD, NOP);
    end
    cyc(0, 0, 0, 0, 0);                                   // C10
    chk("hold_release_req", 32'(ImemReq), 0);
    chk("hold_release_valid", 32'(ValidD), 0);
    cyc(1, 0, 0, 0, 0);                                   // C11
    chk("hold_loaded", 32'(ValidD), 1);
    chk("hold_next_addr", ImemAddr, 32'hC);
    lat = 3;

    // Redirect while waiting on a 3-cycle memory
    push(32'h0640_0313, 32'h100, 32'h104);
    cyc(0, 0, 0, 0, 0);                                   // C12
    chk("c12_req", 32'(ImemReq), 1);
    chk("c12_addr", ImemAddr, 32'hC);
    cyc(0, 0, 0, 0, 0);                                   // C13
    chk("c13_valid", 32'(ValidD), 0);
    cyc(0, 0, 0, 1, 32'h100);                             // C14
    chk("redirect_no_req", 32'(ImemReq), 0);
    cyc(0, 0, 0, 0, 0);                                   // C15
    chk("drop_no_req", 32'(ImemReq), 0);
    chk("drop_valid", 32'(ValidD), 0);
    chk("drop_instr", InstrD, NOP);
    cyc(0, 0, 0, 0, 0);                                   // C16
    chk("redirect_req", 32'(ImemReq), 1);
    chk("redirect_addr", ImemAddr, 32'h100);
    for (int i = 0; i < 3; i++) begin                     // C17..C19
      cyc(0, 0, 0, 0, 0);
      chk("redirect_bubble_valid", 32'(ValidD), 0);
      chk("redirect_bubble_instr", InstrD, NOP);
    end
    cyc(1, 0, 0, 0, 0);                                   // C20
    chk("redirect_loaded", 32'(ValidD), 1);
    lat = 1;

    // Redirect in the same cycle as the response
    push(32'h7D00_0513, 32'h200, 32'h204);
    cyc(0, 0, 0, 0, 0);                                   // C21
    chk("c21_req", 32'(ImemReq), 1);
    chk("c21_addr", ImemAddr, 32'h104);
    cyc(0, 0, 0, 1, 32'h200);                             // C22
    cyc(0, 0, 0, 0, 0);                                   // C23
    chk("same_cycle_req", 32'(ImemReq), 1);
    chk("same_cycle_addr", ImemAddr, 32'h200);
    chk("same_cycle_valid", 32'(ValidD), 0);
    cyc(0, 0, 0, 0, 0);                                   // C24
    cyc(1, 0, 0, 0, 0);                                   // C25
    chk("c25_valid", 32'(ValidD), 1);
    lat = 3;

    // Reset pulsed while waiting, then a spurious strobe
    push(32'h0050_0093, 32'h0, 32'h4);
    cyc(0, 0, 0, 0, 0);                                   // C26
    chk("c26_req", 32'(ImemReq), 1);
    chk("c26_addr", ImemAddr, 32'h204);
    cyc(0, 0, 0, 0, 0);                                   // C27
    @(posedge clk); #1; rst_n = 1'b0; #3;                 // C28
    chk("midrst_req", 32'(ImemReq), 0);
    chk("midrst_valid", 32'(ValidD), 0);
    chk("midrst_instr", InstrD, NOP);
    chk("midrst_pcd", PCD, 0);
    chk("midrst_addr", ImemAddr, 32'h0);
    cyc(1, 0, 0, 0, 0);                                   // C29
    lat = 1;
    @(posedge clk); #1; rst_n = 1'b1; #3;                 // C30
    chk("rel_req", 32'(ImemReq), 0);
    inject = 1'b1;
    cyc(1, 0, 0, 0, 0);                                   // C31
    chk("spurious_req", 32'(ImemReq), 0);
    cyc(0, 0, 0, 0, 0);                                   // C32
    chk("spurious_ignored", 32'(ValidD), 0);
    chk("spurious_instr", InstrD, NOP);
    chk("post_rst_req", 32'(ImemReq), 1);
    chk("post_rst_addr", ImemAddr, 32'h0);
    cyc(0, 0, 0, 0, 0);                                   // C33
    cyc(1, 0, 0, 0, 0);                                   // C34
    chk("post_rst_loaded", 32'(ValidD), 1);

    // Flush wins over stall
    cyc(1, 1, 1, 0, 0);                                   // C35
    cyc(1, 0, 0, 0, 0);                                   // C36
    chk("flush_over_stall_valid", 32'(ValidD), 0);
    chk("flush_over_stall_instr", InstrD, NOP);

    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 StallF  input  1  from hazard unit; holds the PC and blocks new fetch issue.
REQ-005 StallD  input  1  from hazard unit; holds the IF/ID outputs.
REQ-006 FlushD  input  1  from hazard unit; IF/ID outputs become a bubble.
REQ-007 PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-008 PCTargetE  input  32  redirect target, valid when PCSrcE=1.
REQ-009 ImemReq  output  1  single-cycle fetch request to instruction memory.
REQ-010 ImemAddr  output  32  word address of the request (PCF).
REQ-011 ImemValid  input  1  response strobe, at least 1 cycle after ImemReq.
REQ-012 ImemRData  input  32  instruction word, valid with ImemValid.
REQ-013 InstrD / PCD / PCPlus4D  output  32 each  IF/ID register contents.
REQ-014 ValidD  output  1  InstrD holds a real instruction (0 = bubble).

Function
REQ-015 At most one ImemReq outstanding at any time.
REQ-016 FSM states:
- ISSUE: ImemReq=1, ImemAddr=PCF, unless StallF or PCSrcE; go to WAIT once issued.
- WAIT: awaiting ImemValid.
- HOLD: a response is buffered while StallD=1.
- DROP: a stale response is outstanding.
REQ-017 WAIT, ImemValid=1, StallD=0: IF/ID loads {ImemRData, PCF, PCF+4} with ValidD=1; PCF<=PCF+4; state goes to ISSUE.
REQ-018 WAIT, ImemValid=1, StallD=1: the word is buffered and the state goes to HOLD; HOLD loads IF/ID on the first cycle with StallD=0, then goes to ISSUE.
REQ-019 PCSrcE=1 in any state: PCF<=PCTargetE.
- WAIT without ImemValid goes to DROP.
- WAIT with ImemValid in the same cycle discards the response and goes to ISSUE.
- HOLD discards its buffer and goes to ISSUE.
- ISSUE issues no request that cycle.
REQ-020 DROP: the next ImemValid is discarded and the state goes to ISSUE; PCSrcE in DROP updates PCF only.
REQ-021 IF/ID update priority, per cycle:
- FlushD or PCSrcE: ValidD=0, InstrD=32'h0000_0013 (NOP).
- else StallD: hold all outputs.
- else response or HOLD buffer available: load it.
- else: load a bubble (ValidD=0, NOP).
REQ-022 PC arithmetic is modulo 2^32; PCF+4 wraps from 32'hFFFF_FFFC to 0.
REQ-023 Minimum latency: ImemReq in cycle N, ImemValid in N+1, InstrD valid in N+2; sustained throughput is one instruction per 2 cycles.
REQ-024 A StallF assertion never discards an outstanding response.

Reset
REQ-025 While rst_n=0, ImemReq=0 and the state/outputs are:
- state=ISSUE, PCF=RESET_PC
- InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0
- HOLD buffer cleared
REQ-026 Reset asserted mid-request abandons the request; any ImemValid arriving after release without a new request is ignored, because the state is not WAIT/DROP.
REQ-027 The first ImemReq occurs in the first cycle after rst_n deasserts, with ImemAddr=RESET_PC.

Structure
REQ-028 Package riscv_pkg holds the fetch_state_t enum, NOP_INSTR (32'h0000_0013) and the default RESET_PC.
REQ-029 Sub-module if_id_reg implements the IF/ID register with the REQ-021 priority; the FSM, PCF and HOLD buffer live in fetch_unit.

Verification
REQ-030 Reset release, 1-cycle memory: words 0x00500093 at 0x0 and 0x00A00113 at 0x4 appear on InstrD with PCD=0x0 then 0x4, ValidD=1, two cycles apart.
REQ-031 Response arrives while StallD=1 for 3 cycles: outputs hold, word buffered in HOLD, loaded with ValidD=1 on the cycle after StallD falls, and no duplicate request is issued.
REQ-032 PCSrcE=1, PCTargetE=0x100 while WAIT with a 3-cycle memory: the stale word is dropped, the next ImemAddr is 0x100, and InstrD=NOP with ValidD=0 until the 0x100 word arrives.
REQ-033 PCSrcE and ImemValid in the same cycle: the response is discarded, the state goes to ISSUE (not DROP), and ImemAddr=PCTargetE next cycle.
REQ-034 RESET_PC=32'hFFFF_FFFC: PCPlus4D=0 and the next ImemAddr=0x0.
REQ-035 rst_n pulsed low while WAIT: ImemReq=0 during reset, and an ImemValid arriving after release, before any new ImemReq, leaves ValidD=0.
